// File: rtl/model_scalar_integer_accumulator.sv
// Signed accumulator stage behind the scalar integer multiplier.
// Optional saturation on overflow: define SCALAR_ACCUMULATOR_SATURATE_EN.
module model_scalar_integer_accumulator #(
    parameter int DATA_SIZE    = 64,
    parameter int CONTROL_SIZE = 64
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    START,
    output logic                    READY,
    input  logic [CONTROL_SIZE-1:0] SIZE_IN,
    output logic                    DATA_ENABLE,
    input  logic                    DATA_IN_ENABLE,
    input  logic [DATA_SIZE-1:0]    DATA_IN,
    input  logic                    OVERFLOW_IN,
    output logic [DATA_SIZE-1:0]    DATA_OUT,
    output logic                    OVERFLOW_OUT
);

    typedef enum logic [1:0] {
        STARTER_STATE = 2'd0,
        INPUT_STATE   = 2'd1,
        ENDER_STATE   = 2'd2
    } state_t;

    localparam logic [CONTROL_SIZE-1:0] ONE = 1;

`ifdef SCALAR_ACCUMULATOR_SATURATE_EN
    localparam logic [DATA_SIZE-1:0] ACC_MAX = {1'b0, {(DATA_SIZE-1){1'b1}}};
    localparam logic [DATA_SIZE-1:0] ACC_MIN = {1'b1, {(DATA_SIZE-1){1'b0}}};
`endif

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_SIZE-1:0]    acc;
    logic [DATA_SIZE-1:0]    acc_nxt;
    logic [DATA_SIZE-1:0]    sum;
    logic                    add_ovf;
    logic                    ovf;
    logic [CONTROL_SIZE-1:0] size;
    logic [CONTROL_SIZE-1:0] index;
    logic                    last;

    assign last = (index == size - ONE);

    // Wrapping add, signed-overflow detect, and optional clamp.
    always_comb begin
        sum     = acc + DATA_IN;
        add_ovf = (acc[DATA_SIZE-1] == DATA_IN[DATA_SIZE-1]) &&
                  (sum[DATA_SIZE-1] != acc[DATA_SIZE-1]);
`ifdef SCALAR_ACCUMULATOR_SATURATE_EN
        if (add_ovf) begin
            acc_nxt = acc[DATA_SIZE-1] ? ACC_MIN : ACC_MAX;
        end else begin
            acc_nxt = sum;
        end
`else
        acc_nxt = sum;
`endif
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= STARTER_STATE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stray encodings fall back to idle.
    always_comb begin
        state_nxt = state;
        case (state)
            STARTER_STATE: begin
                if (START) begin
                    if (SIZE_IN == '0) begin
                        state_nxt = ENDER_STATE;
                    end else begin
                        state_nxt = INPUT_STATE;
                    end
                end
            end
            INPUT_STATE: begin
                if (DATA_IN_ENABLE && last) begin
                    state_nxt = ENDER_STATE;
                end
            end
            ENDER_STATE: begin
                state_nxt = STARTER_STATE;
            end
            default: begin
                state_nxt = STARTER_STATE;
            end
        endcase
    end

    // Datapath: accumulate, request next product, publish result.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            acc          <= '0;
            ovf          <= 1'b0;
            size         <= '0;
            index        <= '0;
            READY        <= 1'b0;
            DATA_ENABLE  <= 1'b0;
            DATA_OUT     <= '0;
            OVERFLOW_OUT <= 1'b0;
        end else begin
            READY       <= 1'b0;
            DATA_ENABLE <= 1'b0;
            case (state)
                STARTER_STATE: begin
                    if (START) begin
                        size  <= SIZE_IN;
                        acc   <= '0;
                        index <= '0;
                        ovf   <= 1'b0;
                        if (SIZE_IN != '0) begin
                            DATA_ENABLE <= 1'b1;
                        end
                    end
                end
                INPUT_STATE: begin
                    if (DATA_IN_ENABLE) begin
                        acc <= acc_nxt;
                        ovf <= ovf | OVERFLOW_IN | add_ovf;
                        if (!last) begin
                            index       <= index + ONE;
                            DATA_ENABLE <= 1'b1;
                        end
                    end
                end
                ENDER_STATE: begin
                    DATA_OUT     <= acc;
                    OVERFLOW_OUT <= ovf;
                    READY        <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_model_scalar_integer_accumulator.sv
// Directed bench for model_scalar_integer_accumulator (8-bit data).
// Expected values are hand-computed; saturation expectations follow the macro.
module tb_model_scalar_integer_accumulator;

    logic       CLK;
    logic       RST;
    logic       START;
    logic       READY;
    logic [7:0] SIZE_IN;
    logic       DATA_ENABLE;
    logic       DATA_IN_ENABLE;
    logic [7:0] DATA_IN;
    logic       OVERFLOW_IN;
    logic [7:0] DATA_OUT;
    logic       OVERFLOW_OUT;

    int n_cmp = 0;
    int n_bad = 0;
    int de_cnt = 0;
    int rdy_cnt = 0;
    int de_base;
    int rdy_base;

    model_scalar_integer_accumulator #(
        .DATA_SIZE(8),
        .CONTROL_SIZE(8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .START(START),
        .READY(READY),
        .SIZE_IN(SIZE_IN),
        .DATA_ENABLE(DATA_ENABLE),
        .DATA_IN_ENABLE(DATA_IN_ENABLE),
        .DATA_IN(DATA_IN),
        .OVERFLOW_IN(OVERFLOW_IN),
        .DATA_OUT(DATA_OUT),
        .OVERFLOW_OUT(OVERFLOW_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (DATA_ENABLE === 1'b1) de_cnt++;
        if (READY === 1'b1) rdy_cnt++;
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start_run(input logic [7:0] n);
        START   = 1'b1;
        SIZE_IN = n;
        tick();
        START = 1'b0;
    endtask

    task automatic feed(input string tag, input logic [7:0] d,
                        input logic o, input int gap);
        int k;
        k = 0;
        while (DATA_ENABLE !== 1'b1 && k < 10) begin
            tick();
            k++;
        end
        chk({tag, "_de_wait"}, DATA_ENABLE, 1);
        for (int i = 0; i <= gap; i++) tick();
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = d;
        OVERFLOW_IN    = o;
        tick();
        DATA_IN_ENABLE = 1'b0;
        OVERFLOW_IN    = 1'b0;
        DATA_IN        = 8'h00;
    endtask

    task automatic finish_run(input string tag, input logic [7:0] d,
                              input logic o);
        chk({tag, "_ready_early"}, READY, 0);
        tick();
        chk({tag, "_ready"}, READY, 1);
        chk({tag, "_data"}, DATA_OUT, d);
        chk({tag, "_ovf"}, OVERFLOW_OUT, o);
    endtask

    initial begin
        RST            = 1'b0;
        START          = 1'b0;
        SIZE_IN        = 8'd0;
        DATA_IN_ENABLE = 1'b0;
        DATA_IN        = 8'h00;
        OVERFLOW_IN    = 1'b0;
        tick();
        tick();
        chk("rst_data", DATA_OUT, 0);
        chk("rst_ovf", OVERFLOW_OUT, 0);
        chk("rst_ready", READY, 0);
        chk("rst_de", DATA_ENABLE, 0);
        RST = 1'b1;
        tick();

        // 3 + 5 - 2 + 7 = 13
        de_base = de_cnt;
        start_run(8'd4);
        feed("a0", 8'd3, 1'b0, 0);
        feed("a1", 8'd5, 1'b0, 0);
        feed("a2", 8'hFE, 1'b0, 0);
        feed("a3", 8'd7, 1'b0, 0);
        finish_run("a", 8'd13, 1'b0);
        chk("a_de_pulses", de_cnt - de_base, 4);
        tick();
        chk("a_ready_one", READY, 0);

        // Empty run
        de_base = de_cnt;
        start_run(8'd0);
        finish_run("z", 8'd0, 1'b0);
        chk("z_de_pulses", de_cnt - de_base, 0);
        tick();

        // 100 + 100 positive overflow
        start_run(8'd2);
        feed("p0", 8'd100, 1'b0, 0);
        feed("p1", 8'd100, 1'b0, 0);
`ifdef SCALAR_ACCUMULATOR_SATURATE_EN
        finish_run("p", 8'h7F, 1'b1);
`else
        finish_run("p", 8'hC8, 1'b1);
`endif
        tick();

        // -100 + -100 negative overflow
        start_run(8'd2);
        feed("n0", 8'h9C, 1'b0, 0);
        feed("n1", 8'h9C, 1'b0, 0);
`ifdef SCALAR_ACCUMULATOR_SATURATE_EN
        finish_run("n", 8'h80, 1'b1);
`else
        finish_run("n", 8'h38, 1'b1);
`endif
        tick();

        // Stray product while idle must be ignored
        rdy_base = rdy_cnt;
        DATA_IN_ENABLE = 1'b1;
        DATA_IN        = 8'd50;
        OVERFLOW_IN    = 1'b1;
        tick();
        DATA_IN_ENABLE = 1'b0;
        DATA_IN        = 8'h00;
        OVERFLOW_IN    = 1'b0;
        tick();
        chk("stray_de", DATA_ENABLE, 0);
        chk("stray_ready", rdy_cnt - rdy_base, 0);

        // 1 + 2 + 3 with upstream overflow on the second, random gaps
        start_run(8'd3);
        feed("g0", 8'd1, 1'b0, int'($urandom_range(5)));
        feed("g1", 8'd2, 1'b1, int'($urandom_range(5)));
        feed("g2", 8'd3, 1'b0, int'($urandom_range(5)));
        finish_run("g", 8'd6, 1'b1);
        tick();

        // Reset after 2 of 4 products
        rdy_base = rdy_cnt;
        start_run(8'd4);
        feed("r0", 8'd10, 1'b1, 0);
        feed("r1", 8'd20, 1'b0, 0);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        chk("abort_data", DATA_OUT, 0);
        chk("abort_ovf", OVERFLOW_OUT, 0);
        chk("abort_ready", READY, 0);
        chk("abort_de", DATA_ENABLE, 0);
        for (int i = 0; i < 4; i++) tick();
        chk("abort_no_ready", rdy_cnt - rdy_base, 0);
        start_run(8'd1);
        feed("m0", 8'hF7, 1'b0, 0);
        finish_run("m", 8'hF7, 1'b0);
        tick();

        // START held high: mid-run START ignored, back-to-back restart
        de_base = de_cnt;
        START   = 1'b1;
        SIZE_IN = 8'd2;
        tick();
        feed("h0", 8'd10, 1'b0, 0);
        feed("h1", 8'd20, 1'b0, 0);
        SIZE_IN = 8'd1;
        finish_run("h", 8'd30, 1'b0);
        chk("h_de_pulses", de_cnt - de_base, 2);
        tick();
        START = 1'b0;
        chk("b2b_de", DATA_ENABLE, 1);
        feed("b0", 8'd5, 1'b0, 0);
        finish_run("b", 8'd5, 1'b0);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
